// File: rtl/deco_pipe.sv
// RV32I field decoder feeding a DEPTH-entry FIFO toward execute.
// Decode happens on the way in; the head entry drives all field outputs.
module deco_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr_in,
  input  logic [XLEN-1:0]  pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       op,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [XLEN-1:0]  imm,
  output logic [3:0]       instrT,
  output logic             illegal,
  output logic [XLEN-1:0]  pc_out,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [3:0]      t;
    logic            ill;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]   r_cnt;

  logic signed [31:0] w_imm32;
  logic [3:0]         w_t;
  logic               w_ill;
  entry_t             w_entry;
  entry_t             w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [AW-1:0]      w_sel;

  // Opcode class and format-specific immediate, built as 32 bits then sign-extended.
  always_comb begin
    w_t     = 4'd0;
    w_ill   = 1'b0;
    w_imm32 = '0;
    case (instr_in[6:0])
      7'b0110011: w_t = 4'd1;
      7'b0010011: begin
        w_t     = 4'd2;
        w_imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
      end
      7'b0110111: begin
        w_t     = 4'd3;
        w_imm32 = {instr_in[31:12], 12'b0};
      end
      7'b1100011: begin
        w_t     = 4'd4;
        w_imm32 = {{20{instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
      end
      7'b1100111: begin
        w_t     = 4'd5;
        w_imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
      end
      7'b1101111: begin
        w_t     = 4'd6;
        w_imm32 = {{12{instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
      end
      7'b0000011: begin
        w_t     = 4'd7;
        w_imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
      end
      7'b0100011: begin
        w_t     = 4'd8;
        w_imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      end
      7'b0010111: begin
        w_t     = 4'd9;
        w_imm32 = {instr_in[31:12], 12'b0};
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign w_entry = '{instr: instr_in, imm: XLEN'(w_imm32), t: w_t, ill: w_ill, pc: pc_in};

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = in_valid && !w_full && !flush;
  assign w_pop   = !w_empty && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
        r_cnt                   <= r_cnt + CNT_W'(1);
      end
      // Flush drops everything queued, including a same-cycle push.
      if (flush) begin
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // When empty, show the most recently vacated slot so outputs hold the last popped entry.
  assign w_sel  = w_empty ? (r_rd_ptr[AW-1:0] - AW'(1)) : r_rd_ptr[AW-1:0];
  assign w_head = r_mem[w_sel];

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign op        = w_head.instr[6:0];
  assign rd        = w_head.instr[11:7];
  assign rs1       = w_head.instr[19:15];
  assign rs2       = w_head.instr[24:20];
  assign funct3    = w_head.instr[14:12];
  assign funct7    = w_head.instr[31:25];
  assign imm       = w_head.imm;
  assign instrT    = w_head.t;
  assign illegal   = w_head.ill;
  assign pc_out    = w_head.pc;
  assign instr_cnt = r_cnt;

endmodule

// File: doc/deco_pipe.md
# deco_pipe

Parametrised, buffered successor to the combinational RV32I field decoder. It accepts fetched instructions with a PC over a valid/ready handshake and decodes every base-ISA format: R, I-ALU, load, store, branch, JAL, JALR, LUI and AUIPC. It generates the sign-extended immediate, flags illegal opcodes and queues decoded results in a DEPTH-entry FIFO toward the execute stage. It sits between fetch and register-read and counts accepted instructions.

## Interface
- XLEN, 32: width of pc and immediate; immediates sign-extend to XLEN; legal values 32 or 64.
- DEPTH, 2: FIFO entries, power of two, ≥2.
- CNT_W, 32: width of the accepted-instruction counter.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all queued entries (branch redirect).
- in_valid  in  1  instr_in/pc_in valid.
- in_ready  out  1  FIFO can accept.
- instr_in  in  32  raw instruction.
- pc_in  in  XLEN  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- op, rd, rs1, rs2, funct3, funct7  out  7/5/5/5/3/7  fields of instr[6:0], [11:7], [19:15], [24:20], [14:12], [31:25].
- imm  out  XLEN  format-correct sign-extended immediate.
- instrT  out  4  class code.
- illegal  out  1  unrecognised opcode.
- pc_out  out  XLEN  PC of head entry.
- instr_cnt  out  CNT_W  accepted-instruction count.

## Operation
- **Push.** Occurs on in_valid && in_ready. Decode is combinational on instr_in; the decoded bundle is written at the tail.
- **Pop.** Occurs on out_valid && out_ready. The head pointer advances.
- **instrT encoding.** Keyed by opcode.
  - 0 = illegal
  - 1 = R (0110011)
  - 2 = I-ALU (0010011)
  - 3 = LUI (0110111)
  - 4 = branch (1100011)
  - 5 = JALR (1100111)
  - 6 = JAL (1101111)
  - 7 = load (0000011)
  - 8 = store (0100011)
  - 9 = AUIPC (0010111)
  - Any other opcode gives instrT=0 and illegal=1.
- **Immediate rules** (sign bit instr[31], extended to XLEN):
  - I/load/JALR: instr[31:20].
  - Store: {instr[31:25], instr[11:7]}.
  - Branch: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - LUI/AUIPC: {instr[31:12], 12'b0}, then sign-extended.
  - JAL: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - R/illegal: 0.
- **Field outputs.** Driven from the head entry regardless of class.
- **Illegal instructions.** Queued and popped like any other entry; no stall.
- **Pointers.** log2(DEPTH)+1 bits each; an extra wrap bit distinguishes full from empty.
- **in_ready.** Equals !full. It does not look at out_ready, so there is no combinational ready path. A pop while full frees a slot only on the next cycle.
- **flush.** Empties the FIFO at the next edge. It takes priority over a simultaneous push and pop; the pushed instruction is dropped and not counted.
- **instr_cnt.** Increments by 1 per accepted push and wraps modulo 2^CNT_W. It is not cleared by flush.

## Timing
- **Reset values** (all while rst_n=0, immediately, asynchronous):
  - Pointers 0; out_valid=0; in_ready=1; instr_cnt=0.
  - All data outputs 0: op, rd, rs1, rs2, funct3, funct7, imm, pc_out, instrT=0, illegal=0.
- **Latency.** 1 cycle: an instruction accepted at edge N is visible with out_valid=1 after edge N, provided the FIFO was empty.
- **Throughput.** One instruction per cycle sustained while the consumer is ready.
- **Empty FIFO.** Data outputs hold the last popped entry's values and must not be used; out_valid=0 is authoritative.
- **Simultaneous push and pop.**
  - When not full: occupancy is unchanged.
  - When empty: only the push takes effect; there is no bypass.
- **Full.** in_ready=0; input is held by the producer.
- **Reset mid-stream.** All queued entries are lost and instr_cnt returns to 0.

## Test plan
- **Reset.** Assert rst_n=0 mid-stream with 2 entries queued → out_valid=0, in_ready=1, instr_cnt=0 immediately.
- **I-format and illegal decode.**
  - Push 0xFFF10093 (addi x1,x2,-1) → one cycle later out_valid=1, instrT=2, rd=1, rs1=2, imm=0xFFFFFFFF, illegal=0.
  - Push 0x0000007F → instrT=0, illegal=1, imm=0.
- **Branch and LUI immediates.**
  - Push 0xFE000EE3 (beq x0,x0,-4) → instrT=4, imm=0xFFFFFFFC.
  - Push 0x123452B7 (lui x5,0x12345) → instrT=3, rd=5, imm=0x12345000.
- **Store immediate.** Push 0x0020A423 (sw x2,8(x1)) → instrT=8, rs1=1, rs2=2, funct3=2, imm=0x00000008.
- **Backpressure and ordering.** DEPTH=2, out_ready=0, present 3 instructions → in_ready falls after 2 accepts. Raise out_ready → pops occur in push order with matching pc_out, then the third instruction is accepted. instr_cnt=3 at the end.
- **Flush.** Flush while 2 entries are queued, with a push in the same cycle → out_valid=0 next cycle, the pushed instruction never appears, instr_cnt unchanged.
